// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: request, data-memory bus and response signals of the
// load/store unit, bundled as one interface.
//   slave  modport: seen from the LSU (takes requests, drives the bus/response)
//   master modport: seen from the core/memory side (drives requests, answers bus)
// Signals:
//   req_valid/req_ready/req_is_store/req_funct3/req_addr/req_wdata : request
//   mem_valid/mem_ready/mem_addr/mem_wstrb/mem_wdata/mem_rdata     : memory bus
//   rsp_valid/rsp_data/rsp_err                                     : response
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  mem_ready, mem_rdata,
    output req_ready, mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output mem_ready, mem_rdata,
    input  req_ready, mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32I load/store unit. Takes one request at a time, checks
// funct3 legality and alignment, runs a word-addressed valid/ready bus access
// with byte strobes and replicated store lanes, and returns extended load data
// or an error as a one-cycle response pulse.
// Ports:
//   clk      : clock
//   reset_n  : synchronous active-low reset
//   bus      : lsu_mem_port_if.slave (request, memory bus, response)
// Parameter:
//   TIMEOUT_CYCLES : bus cycles to wait for mem_ready before an error; 0 = never
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// BUS   | mem_valid high, waiting for mem_ready or timeout
// RESP  | rsp_valid pulse for one cycle
module lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            reset_n,
  lsu_mem_port_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_store_q, is_store_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] cnt_q, cnt_d;

  logic        req_legal, req_misaligned;
  logic [3:0]  req_strb;
  logic [31:0] req_lanes;
  logic [31:0] rd_shifted, load_ext;
  logic [31:0] cnt_inc;
  logic        timeout_hit;

  // Request decode
  always_comb begin
    if (bus.req_is_store)
      req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010);
    else
      req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                  (bus.req_funct3 == 3'b101);
    req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    case (bus.req_funct3[1:0])
      2'b00:   begin
        req_strb  = 4'b0001 << bus.req_addr[1:0];
        req_lanes = {4{bus.req_wdata[7:0]}};
      end
      2'b01:   begin
        req_strb  = 4'b0011 << {bus.req_addr[1], 1'b0};
        req_lanes = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        req_strb  = 4'b1111;
        req_lanes = bus.req_wdata;
      end
    endcase
  end

  // Load lane extraction; LW is only reached with addr_lo_q == 0
  always_comb begin
    rd_shifted = bus.mem_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  load_ext = {24'h0, rd_shifted[7:0]};
      3'b101:  load_ext = {16'h0, rd_shifted[15:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  // cnt_inc counts the current BUS cycle too, so the bus stays valid for
  // exactly TIMEOUT_CYCLES cycles before giving up
  assign cnt_inc     = cnt_q + 32'd1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_CYCLES);

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    addr_lo_d   = addr_lo_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          funct3_d   = bus.req_funct3;
          is_store_d = bus.req_is_store;
          addr_lo_d  = bus.req_addr[1:0];
          if (!req_legal || req_misaligned) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = 32'h0;
            state_d    = RESP;
          end else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_wstrb_d = bus.req_is_store ? req_strb : 4'b0000;
            mem_wdata_d = bus.req_is_store ? req_lanes : 32'h0;
            cnt_d       = 32'h0;
            state_d     = BUS;
          end
        end
      end
      BUS: begin
        if (bus.mem_ready || timeout_hit) begin
          rsp_err_d   = !bus.mem_ready;
          rsp_data_d  = (bus.mem_ready && !is_store_q) ? load_ext : 32'h0;
          mem_valid_d = 1'b0;
          mem_addr_d  = 32'h0;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      funct3_q    <= 3'b000;
      is_store_q  <= 1'b0;
      addr_lo_q   <= 2'b00;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      addr_lo_q   <= addr_lo_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
